// File: rtl/nonogram_pkg.sv
// nonogram_pkg: command types, stream flag codes and header helper shared by encoder and parser
package nonogram_pkg;
  typedef enum logic [1:0] {
    BOARD_START = 2'd0,
    OPTION      = 2'd1,
    BOARD_END   = 2'd2,
    CMD_RSVD    = 2'd3
  } cmd_type_e;
  localparam logic [2:0] F_START_BOARD = 3'b111;
  localparam logic [2:0] F_END_BOARD   = 3'b000;
  localparam logic [2:0] F_START_LINE  = 3'b110;
  localparam logic [2:0] F_END_LINE    = 3'b001;
  localparam logic [2:0] F_AND         = 3'b101;
  localparam logic [2:0] F_OR          = 3'b010;
  localparam logic [3:0] MAX_DIM       = 4'd11;
  function automatic logic [7:0] hdr_byte(input logic [2:0] flag);
    return {flag, 5'b0};
  endfunction
endpackage

// File: rtl/nonogram_encoder_if.sv
// nonogram_encoder_if: command input and byte-stream output of the nonogram encoder
interface nonogram_encoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_n;
  logic [3:0]  cmd_m;
  logic [15:0] cmd_option;
  logic        cmd_first;
  logic        cmd_last;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  line_idx;
  logic        busy;
  logic        err;
  modport master (
    output cmd_valid, cmd_type, cmd_n, cmd_m, cmd_option, cmd_first, cmd_last, tx_ready,
    input  cmd_ready, tx_byte, tx_valid, line_idx, busy, err
  );
  modport slave (
    input  cmd_valid, cmd_type, cmd_n, cmd_m, cmd_option, cmd_first, cmd_last, tx_ready,
    output cmd_ready, tx_byte, tx_valid, line_idx, busy, err
  );
endinterface

// File: rtl/nonogram_encoder.sv
// nonogram_encoder: expands board/option commands into a header/payload byte-pair stream
module nonogram_encoder
  import nonogram_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  nonogram_encoder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2;
  localparam logic [2:0] SB_N = 3'd0, SB_M = 3'd1, SL = 3'd2, CELL = 3'd3, SEP = 3'd4, EB = 3'd5;
  logic [1:0]  state;
  logic [2:0]  tok;
  logic [3:0]  idx, n, m, len;
  logic [4:0]  line;
  logic [15:0] opt;
  logic        active, last, err_q, acc, bad_dim, rej;
  logic [2:0]  flag;
  logic [7:0]  pay;
  always_comb begin
    len     = (line < {1'b0, m}) ? n : m;
    flag    = (tok == SB_N || tok == SB_M) ? F_START_BOARD :
              (tok == SL)   ? F_START_LINE :
              (tok == CELL) ? F_AND :
              (tok == SEP)  ? (last ? F_END_LINE : F_OR) : F_END_BOARD;
    pay     = (tok == SB_N) ? {3'b0, n, 1'b0} :
              (tok == SB_M) ? {3'b0, m, 1'b0} :
              (tok == CELL) ? {3'b0, idx, opt[idx]} : 8'h00;
    acc     = bus.cmd_valid && bus.cmd_ready;
    bad_dim = bus.cmd_n == 4'd0 || bus.cmd_n > MAX_DIM || bus.cmd_m == 4'd0 || bus.cmd_m > MAX_DIM;
    rej     = (bus.cmd_type == OPTION)      ? (!active || line == ({1'b0, n} + {1'b0, m})) :
              (bus.cmd_type == BOARD_START) ? bad_dim : (bus.cmd_type == CMD_RSVD);
  end
  assign bus.cmd_ready = rst_n && state == IDLE;
  assign bus.tx_valid  = state != IDLE;
  assign bus.tx_byte   = (state == HDR) ? hdr_byte(flag) : (state == PAY) ? pay : 8'h00;
  assign bus.busy      = state != IDLE;
  assign bus.line_idx  = line;
  assign bus.err       = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tok    <= SB_N;
      idx    <= 4'd0;
      n      <= 4'd0;
      m      <= 4'd0;
      line   <= 5'd0;
      opt    <= 16'd0;
      active <= 1'b0;
      last   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == IDLE) begin
        if (acc && rej) err_q <= 1'b1;
        else if (acc) begin
          state <= HDR;
          idx   <= 4'd0;
          if (bus.cmd_type == BOARD_START) begin
            n      <= bus.cmd_n;
            m      <= bus.cmd_m;
            line   <= 5'd0;
            active <= 1'b1;
            tok    <= SB_N;
          end else if (bus.cmd_type == OPTION) begin
            opt  <= bus.cmd_option;
            last <= bus.cmd_last;
            tok  <= bus.cmd_first ? SL : CELL;
          end else begin
            active <= 1'b0;
            tok    <= EB;
          end
        end
      end else if (bus.tx_ready) begin
        if (state == HDR) state <= PAY;
        else begin
          state <= HDR;
          if (tok == SB_N) tok <= SB_M;
          else if (tok == SL) tok <= CELL;
          else if (tok == CELL) begin
            if (idx == len - 4'd1) tok <= SEP;
            else idx <= idx + 4'd1;
          end else begin
            // SB_M, SEP and EB close their command
            state <= IDLE;
            if (tok == SEP && last) line <= line + 5'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nonogram_encoder.sv
// tb_nonogram_encoder: directed and randomized commands checked against a rule-level stream model
module tb_nonogram_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int mn = 0, mm = 0, mline = 0;
  bit mact = 0;
  bit exp_rej;
  logic [7:0] exp_q[$];
  nonogram_encoder_if bus();
  nonogram_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_cmd(input int t, input int n, input int m, input logic [15:0] opt, input bit f, input bit l);
    int len;
    exp_q.delete();
    exp_rej = 0;
    if (t == 0) begin
      if (n < 1 || n > 11 || m < 1 || m > 11) exp_rej = 1;
      else begin
        exp_q = '{8'hE0, 8'(n * 2), 8'hE0, 8'(m * 2)};
        mn = n; mm = m; mline = 0; mact = 1;
      end
    end else if (t == 1) begin
      if (!mact || mline == mn + mm) exp_rej = 1;
      else begin
        if (f) begin exp_q.push_back(8'hC0); exp_q.push_back(8'h00); end
        len = (mline < mm) ? mn : mm;
        for (int i = 0; i < len; i++) begin
          exp_q.push_back(8'hA0);
          exp_q.push_back(8'(i * 2 + int'(opt[i])));
        end
        exp_q.push_back(l ? 8'h20 : 8'h40);
        exp_q.push_back(8'h00);
        if (l) mline++;
      end
    end else if (t == 2) begin
      exp_q = '{8'h00, 8'h00};
      mact = 0;
    end else exp_rej = 1;
  endtask
  task automatic run_cmd(input int t, input int n, input int m, input logic [15:0] opt,
                         input bit f, input bit l, input int mode);
    logic [7:0] got[$];
    logic [7:0] held;
    bit stall;
    int cyc;
    model_cmd(t, n, m, opt, f, l);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_type   = 2'(t);
    bus.cmd_n      = 4'(n);
    bus.cmd_m      = 4'(m);
    bus.cmd_option = opt;
    bus.cmd_first  = f;
    bus.cmd_last   = l;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_n      = 4'($urandom);
    bus.cmd_m      = 4'($urandom);
    bus.cmd_option = 16'($urandom);
    if (exp_rej) begin
      chk("err_pulse", bus.err, 1);
      chk("no_tx_on_reject", bus.tx_valid, 0);
      @(posedge clk); #1;
      chk("err_clear", bus.err, 0);
    end else begin
      chk("tx_valid_after_accept", bus.tx_valid, 1);
      stall = 0;
      cyc = 0;
      while (got.size() < exp_q.size() && cyc < 400) begin
        if (stall) chk("hold_stable", bus.tx_byte, held);
        chk("tx_valid_held", bus.tx_valid, 1);
        bus.tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_byte);
        stall = bus.tx_valid && !bus.tx_ready;
        held = bus.tx_byte;
        @(posedge clk); #1;
        cyc++;
      end
      chk("byte_count", got.size(), exp_q.size());
      foreach (exp_q[i]) if (i < got.size()) chk($sformatf("byte%0d", i), got[i], exp_q[i]);
      if (mode == 0) chk("cycles_to_idle", cyc, exp_q.size());
      chk("idle_ready", bus.cmd_ready, 1);
      chk("busy_low", bus.busy, 0);
      chk("tx_valid_low", bus.tx_valid, 0);
    end
    chk("line_idx", bus.line_idx, mline);
  endtask
  initial begin
    bus.cmd_valid = 0; bus.cmd_type = 0; bus.cmd_n = 0; bus.cmd_m = 0;
    bus.cmd_option = 0; bus.cmd_first = 0; bus.cmd_last = 0; bus.tx_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_line_idx", bus.line_idx, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_after_release", bus.cmd_ready, 1);
    run_cmd(1, 0, 0, 16'h0005, 1, 1, 0);
    run_cmd(0, 3, 2, 16'h0000, 0, 0, 0);
    run_cmd(1, 0, 0, 16'h0005, 1, 1, 0);
    run_cmd(1, 0, 0, 16'h0005, 1, 1, 1);
    run_cmd(1, 0, 0, 16'($urandom), 1, 0, 2);
    run_cmd(1, 0, 0, 16'($urandom), 0, 1, 2);
    run_cmd(1, 0, 0, 16'($urandom), 1, 1, 0);
    run_cmd(1, 0, 0, 16'($urandom), 1, 1, 1);
    run_cmd(1, 0, 0, 16'($urandom), 1, 1, 0);
    run_cmd(3, 0, 0, 16'h0, 0, 0, 0);
    run_cmd(0, 12, 3, 16'h0, 0, 0, 0);
    run_cmd(0, 4, 0, 16'h0, 0, 0, 0);
    run_cmd(2, 0, 0, 16'h0, 0, 0, 0);
    run_cmd(1, 0, 0, 16'hFFFF, 1, 1, 0);
    run_cmd(0, 11, 11, 16'h0, 0, 0, 2);
    run_cmd(1, 0, 0, 16'($urandom), 1, 1, 2);
    run_cmd(0, 4, 3, 16'h0, 0, 0, 0);
    run_cmd(1, 0, 0, 16'hFFFF, 1, 1, 0);
    run_cmd(0, 2, 2, 16'h0, 0, 0, 1);
    for (int k = 0; k < 60; k++) begin
      int r, t;
      r = $urandom_range(0, 9);
      t = (r < 2) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      run_cmd(t, $urandom_range(0, 13), $urandom_range(0, 13), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end
    run_cmd(0, 3, 2, 16'h0, 0, 0, 0);
    bus.tx_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_type = 2'd1; bus.cmd_first = 1'b0; bus.cmd_last = 1'b0;
    bus.cmd_option = 16'($urandom);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("mid_hdr_and", bus.tx_byte, 8'hA0);
    @(posedge clk); #1;
    chk("mid_pay_valid", bus.tx_valid, 1);
    rst_n = 1'b0;
    mact = 0; mn = 0; mm = 0; mline = 0;
    #1;
    chk("mid_rst_tx_valid", bus.tx_valid, 0);
    chk("mid_rst_tx_byte", bus.tx_byte, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_line_idx", bus.line_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("mid_rst_ready_release", bus.cmd_ready, 1);
    run_cmd(1, 0, 0, 16'h0001, 1, 1, 0);
    run_cmd(0, 1, 1, 16'h0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
